// File: rtl/pulse_width_meter.sv
// Pulse width meter: measures the high time of an asynchronous input in whole
// microseconds. A prescaler driven by clk forms the microsecond tick. Results
// are handed to the reader one at a time through a valid/ack handshake.
module pulse_width_meter #(
  parameter int unsigned CLK_PER_US = 20,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             meas_ack,
  output logic [CNT_W-1:0] meas_us,
  output logic             meas_ovf,
  output logic             meas_valid,
  output logic             busy
);

  localparam int unsigned PRE_W = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_PER_US - 1);
  localparam logic [CNT_W-1:0] US_MAX   = '1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEASURE  = 2'd1,
    WAIT_ACK = 2'd2,
    ARM      = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic             s1_q, s2_q, s3_q;
  logic             loaded_q, low_seen_q;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CNT_W-1:0] us_q, us_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] meas_us_q, meas_us_d;
  logic             meas_ovf_q, meas_ovf_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             rise_c, fall_c;

  assign rise_c = s2_q & ~s3_q;
  assign fall_c = ~s2_q & s3_q;

  // Two-flop synchronizer plus history flop. low_seen_q records that a real
  // low level has been sampled since reset, so a pulse already high when reset
  // is released is treated as partial and not measured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      s3_q       <= 1'b0;
      loaded_q   <= 1'b0;
      low_seen_q <= 1'b0;
    end else begin
      s1_q       <= sig_in;
      s2_q       <= s1_q;
      s3_q       <= s2_q;
      loaded_q   <= 1'b1;
      low_seen_q <= low_seen_q | (loaded_q & ~s1_q);
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pre_q      <= '0;
      us_q       <= '0;
      ovf_q      <= 1'b0;
      meas_us_q  <= '0;
      meas_ovf_q <= 1'b0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      us_q       <= us_d;
      ovf_q      <= ovf_d;
      meas_us_q  <= meas_us_d;
      meas_ovf_q <= meas_ovf_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
    end
  end

  // Next-state, counting and handshake logic.
  always_comb begin
    state_d    = state_q;
    pre_d      = pre_q;
    us_d       = us_q;
    ovf_d      = ovf_q;
    meas_us_d  = meas_us_q;
    meas_ovf_d = meas_ovf_q;
    valid_d    = valid_q;

    unique case (state_q)
      IDLE: begin
        // The rise-detect cycle is the first counted high cycle.
        if (rise_c && low_seen_q) begin
          pre_d   = PRE_W'(1);
          us_d    = '0;
          ovf_d   = 1'b0;
          state_d = MEASURE;
        end
      end
      MEASURE: begin
        if (fall_c) begin
          meas_us_d  = us_q;
          meas_ovf_d = ovf_q;
          valid_d    = 1'b1;
          state_d    = WAIT_ACK;
        end else if (s2_q) begin
          if (pre_q == PRE_LAST) begin
            pre_d = '0;
            if (us_q == US_MAX) begin
              ovf_d = 1'b1;
            end else begin
              us_d = us_q + CNT_W'(1);
            end
          end else begin
            pre_d = pre_q + PRE_W'(1);
          end
        end
      end
      WAIT_ACK: begin
        if (meas_ack) begin
          valid_d    = 1'b0;
          meas_us_d  = '0;
          meas_ovf_d = 1'b0;
          state_d    = ARM;
        end
      end
      ARM: begin
        // Wait out any pulse already in progress.
        if (!s2_q) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == MEASURE);
  end

  assign meas_us    = meas_us_q;
  assign meas_ovf   = meas_ovf_q;
  assign meas_valid = valid_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter: two instances (16-bit and 4-bit results) share
// stimulus; expected results are queued when a pulse is driven and popped when
// meas_valid is seen.
module tb_pulse_width_meter;

  localparam int unsigned CPU = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sig_in;
  logic        meas_ack;
  logic [15:0] us_a;
  logic        ovf_a, valid_a, busy_a;
  logic [3:0]  us_b;
  logic        ovf_b, valid_b, busy_b;

  always #5 clk = ~clk;

  pulse_width_meter #(.CLK_PER_US(CPU), .CNT_W(16)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_ack(meas_ack),
    .meas_us(us_a), .meas_ovf(ovf_a), .meas_valid(valid_a), .busy(busy_a)
  );

  pulse_width_meter #(.CLK_PER_US(CPU), .CNT_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .sig_in(sig_in), .meas_ack(meas_ack),
    .meas_us(us_b), .meas_ovf(ovf_b), .meas_valid(valid_b), .busy(busy_b)
  );

  typedef struct {
    int unsigned us_a;
    bit          ovf_a;
    int unsigned us_b;
    bit          ovf_b;
  } exp_t;

  typedef struct {
    int unsigned n;
    exp_t        e;
  } vec_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic exp_t model(input int unsigned n);
    exp_t e;
    int unsigned us;
    us      = n / CPU;
    e.ovf_a = (us > 65535);
    e.us_a  = e.ovf_a ? 65535 : us;
    e.ovf_b = (us > 15);
    e.us_b  = e.ovf_b ? 15 : us;
    return e;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pulse(input int unsigned n);
    sig_in = 1'b1;
    repeat (n) step();
    sig_in = 1'b0;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, " valid_a"}, valid_a, 0);
    chk({name, " valid_b"}, valid_b, 0);
    chk({name, " busy_a"}, busy_a, 0);
    chk({name, " us_a"}, us_a, 0);
  endtask

  // Wait (bounded) for meas_valid, then pop and compare one result.
  task automatic collect(input string name, output int unsigned waited);
    exp_t e;
    waited = 0;
    while (!valid_a && waited < 10) begin
      step();
      waited++;
    end
    chk({name, " valid_a"}, valid_a, 1);
    chk({name, " valid_b"}, valid_b, 1);
    if (sb.size() == 0) begin
      chk({name, " scoreboard empty"}, 0, 1);
    end else begin
      e = sb.pop_front();
      chk({name, " us_a"}, us_a, e.us_a);
      chk({name, " ovf_a"}, ovf_a, 32'(e.ovf_a));
      chk({name, " us_b"}, us_b, e.us_b);
      chk({name, " ovf_b"}, ovf_b, 32'(e.ovf_b));
    end
  endtask

  task automatic do_ack(input string name);
    meas_ack = 1'b1;
    step();
    meas_ack = 1'b0;
    chk({name, " ack valid_a"}, valid_a, 0);
    chk({name, " ack valid_b"}, valid_b, 0);
    chk({name, " ack us_a"}, us_a, 0);
    chk({name, " ack ovf_b"}, ovf_b, 0);
    step();
  endtask

  // Full pulse/measure/ack cycle with exact latency and busy checks.
  task automatic run_pulse(input string name, input int unsigned n, input exp_t e);
    int unsigned waited;
    sb.push_back(e);
    drive_pulse(n);
    step();
    step();
    chk({name, " early valid"}, valid_a, 0);
    chk({name, " busy in pulse"}, busy_a, 1);
    collect(name, waited);
    chk({name, " latency"}, waited, 1);
    chk({name, " busy after"}, busy_a, 0);
    repeat (2) step();
    chk({name, " held us_a"}, us_a, e.us_a);
    do_ack(name);
    repeat (3) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation timed out, expected finish");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    int unsigned waited;

    vecs[0] = '{n: 60,  e: '{3,  1'b0, 3,  1'b0}};
    vecs[1] = '{n: 59,  e: '{2,  1'b0, 2,  1'b0}};
    vecs[2] = '{n: 19,  e: '{0,  1'b0, 0,  1'b0}};
    vecs[3] = '{n: 20,  e: '{1,  1'b0, 1,  1'b0}};
    vecs[4] = '{n: 1,   e: '{0,  1'b0, 0,  1'b0}};
    vecs[5] = '{n: 400, e: '{20, 1'b0, 15, 1'b1}};
    vecs[6] = '{n: 40,  e: '{2,  1'b0, 2,  1'b0}};
    vecs[7] = '{n: 319, e: '{15, 1'b0, 15, 1'b0}};
    vecs[8] = '{n: 320, e: '{16, 1'b0, 15, 1'b1}};
    vecs[9] = '{n: 2,   e: '{0,  1'b0, 0,  1'b0}};

    rst_n    = 1'b0;
    sig_in   = 1'b0;
    meas_ack = 1'b0;
    repeat (3) step();
    chk_quiet("reset");
    chk("reset ovf_a", ovf_a, 0);
    rst_n = 1'b1;
    repeat (4) step();

    // Ack while idle is ignored.
    meas_ack = 1'b1;
    repeat (2) step();
    meas_ack = 1'b0;
    step();
    chk_quiet("idle ack");

    foreach (vecs[i]) begin
      run_pulse($sformatf("vec%0d n=%0d", i, vecs[i].n), vecs[i].n, vecs[i].e);
    end

    // Ack held low: second pulse ignored, third aborted by ack mid-pulse.
    sb.push_back(model(40));
    drive_pulse(40);
    collect("hold p40", waited);
    drive_pulse(80);
    repeat (5) step();
    chk("hold p80 valid", valid_a, 1);
    chk("hold p80 us_a", us_a, 2);
    chk("hold p80 busy", busy_a, 0);
    sig_in = 1'b1;
    repeat (10) step();
    meas_ack = 1'b1;
    step();
    meas_ack = 1'b0;
    chk("arm ack valid", valid_a, 0);
    repeat (30) step();
    chk("arm busy", busy_a, 0);
    sig_in = 1'b0;
    repeat (10) step();
    chk_quiet("arm no result");
    run_pulse("after arm p20", 20, model(20));

    // Reset in the middle of a 100-cycle pulse discards everything.
    sig_in = 1'b1;
    repeat (50) step();
    chk("pre-reset busy", busy_a, 1);
    rst_n = 1'b0;
    #1;
    chk_quiet("mid reset");
    chk("mid reset busy_b", busy_b, 0);
    step();
    rst_n = 1'b1;
    repeat (20) step();
    chk("partial busy", busy_a, 0);
    repeat (29) step();
    sig_in = 1'b0;
    repeat (12) step();
    chk_quiet("partial no result");
    run_pulse("post reset p40", 40, model(40));

    // Ack held high throughout: one result per pulse, dropped next cycle.
    meas_ack = 1'b1;
    sb.push_back(model(40));
    drive_pulse(40);
    collect("ack held p40", waited);
    chk("ack held latency", waited, 3);
    step();
    chk("ack held drop", valid_a, 0);
    repeat (4) step();
    sb.push_back(model(25));
    drive_pulse(25);
    collect("ack held p25", waited);
    step();
    chk("ack held drop2", valid_a, 0);
    meas_ack = 1'b0;
    repeat (3) step();

    // Single-cycle glitch still yields a zero result.
    run_pulse("glitch", 1, model(1));

    chk("scoreboard drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
